// File: rtl/data_bus_arbiter_if.sv
// rtl/data_bus_arbiter_if.sv - master-side requests and shared slave port of the data bus arbiter
interface data_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0]    m_req_i;
  logic [NUM_MASTERS-1:0]    m_we_i;
  logic [4*NUM_MASTERS-1:0]  m_be_i;
  logic [32*NUM_MASTERS-1:0] m_addr_i;
  logic [32*NUM_MASTERS-1:0] m_wdata_i;
  logic [31:0]               m_rdata_o;
  logic [NUM_MASTERS-1:0]    m_ack_o;
  logic                      m_err_o;
  logic                      s_req_o;
  logic                      s_we_o;
  logic [3:0]                s_be_o;
  logic [31:0]               s_addr_o;
  logic [31:0]               s_wdata_o;
  logic [31:0]               s_rdata_i;
  logic                      s_ack_i;
  logic [NUM_MASTERS-1:0]    grant_o;
  logic                      busy_o;

  // Environment side: drives the requesters and the slave response.
  modport master (
    output m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i, s_rdata_i, s_ack_i,
    input  m_rdata_o, m_ack_o, m_err_o, s_req_o, s_we_o, s_be_o, s_addr_o,
           s_wdata_o, grant_o, busy_o
  );

  // Arbiter side.
  modport slave (
    input  m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i, s_rdata_i, s_ack_i,
    output m_rdata_o, m_ack_o, m_err_o, s_req_o, s_we_o, s_be_o, s_addr_o,
           s_wdata_o, grant_o, busy_o
  );
endinterface

// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - round-robin data bus arbiter with locked grant and per-transfer timeout
module data_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 16
) (
  input logic              clk_i,
  input logic              rst_n_i,
  data_bus_arbiter_if.slave bus
);
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_MASTERS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_n;
  logic [NUM_MASTERS-1:0] grant, grant_n;
  logic [IW-1:0]          g_idx, g_idx_n;
  logic [IW-1:0]          rr, rr_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic                   found;
  logic [IW-1:0]          sel;
  logic                   timeout_hit;
  logic                   done;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      grant <= '0;
      g_idx <= '0;
      rr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      g_idx <= g_idx_n;
      rr    <= rr_n;
      cnt   <= cnt_n;
    end
  end

  // First requester at or above the rr pointer, wrapping around.
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = rr;
    idx   = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = int'(rr) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && bus.m_req_i[idx]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
  end

  // A same-cycle ack suppresses the timeout, so the slave's data wins.
  assign timeout_hit = (TIMEOUT != 0) && (state == BUSY) && (cnt == CNT_LAST) && !bus.s_ack_i;
  assign done        = (state == BUSY) && (bus.s_ack_i || timeout_hit);

  always_comb begin
    state_n = state;
    grant_n = grant;
    g_idx_n = g_idx;
    rr_n    = rr;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_n      = BUSY;
          grant_n      = '0;
          grant_n[sel] = 1'b1;
          g_idx_n      = sel;
          cnt_n        = '0;
        end
      end
      BUSY: begin
        if (done) begin
          state_n = IDLE;
          grant_n = '0;
          cnt_n   = '0;
          rr_n    = (g_idx == IDX_LAST) ? '0 : IW'(g_idx + 1'b1);
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.s_req_o   = 1'b0;
    bus.s_we_o    = 1'b0;
    bus.s_be_o    = '0;
    bus.s_addr_o  = '0;
    bus.s_wdata_o = '0;
    bus.m_ack_o   = '0;
    bus.m_err_o   = 1'b0;
    bus.m_rdata_o = '0;
    if (state == BUSY) begin
      bus.s_req_o   = 1'b1;
      bus.s_we_o    = bus.m_we_i[g_idx];
      bus.s_be_o    = bus.m_be_i[int'(g_idx)*4 +: 4];
      bus.s_addr_o  = bus.m_addr_i[int'(g_idx)*32 +: 32];
      bus.s_wdata_o = bus.m_wdata_i[int'(g_idx)*32 +: 32];
      bus.m_ack_o   = done ? grant : '0;
      bus.m_err_o   = timeout_hit;
      bus.m_rdata_o = bus.s_ack_i ? bus.s_rdata_i : '0;
    end
  end

  assign bus.grant_o = grant;
  assign bus.busy_o  = (state == BUSY);
endmodule
